// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell reused LSB-first over WIDTH cycles.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             br;
  logic [CntW-1:0]  cnt;

  logic cell_d;
  logic cell_bout;

  full_subtractor u_cell (
    .x    (ra[0]),
    .y    (rb[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // rd[0] only ever holds the cleared seed bit; it falls off the end on the final shift.
  logic unused_rd_lsb;
  assign unused_rd_lsb = rd[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      ra     <= '0;
      rb     <= '0;
      rd     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            rd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StShift;
          end else begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        StShift: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rd  <= {cell_d, rd[WIDTH-1:1]};
          br  <= cell_bout;
          cnt <= cnt + CntW'(1);
          if (cnt == LastBit) begin
            diff   <= {cell_d, rd[WIDTH-1:1]};
            borrow <= cell_bout;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= StDone;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
